mul32_iter: RTL and testbench
=============================

Name: mul32_iter

Overview:
- Iterative 32x32 radix-2 shift-add multiplier in the EX stage of the pipelined processor.
- Sits beside the bitwise logic units (OR/AND arrays) and the adder; its product feeds the EX result mux and the HI/LO write path.
- Hazard logic stalls the pipeline while `busy` is high; the start/busy/done handshake supports the stall.
- Supports signed and unsigned operands.

Parameters:
- WIDTH, 32, operand width; the product is 2*WIDTH bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- start  in  1  request a multiply; sampled only when the unit is not busy
- is_signed  in  1  1 = two's-complement operands, 0 = unsigned; sampled with start
- kill  in  1  pipeline squash; aborts any operation in flight
- a  in  WIDTH  multiplicand, sampled with start
- b  in  WIDTH  multiplier, sampled with start
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse: result valid
- prod_hi  out  WIDTH  upper half of the product
- prod_lo  out  WIDTH  lower half of the product

Behaviour:
- Reset (synchronous, active-high):
  - state = IDLE; busy, done, prod_hi, prod_lo, counter and internal registers are all 0.
  - Reset wins over start and kill in the same cycle.
- States: IDLE, RUN, FIX, DONE. Encoding is 2 bits.
- IDLE or DONE, with start=1 and kill=0 at edge k:
  - capture |a| and |b| (magnitudes if is_signed=1, raw values otherwise);
  - neg = is_signed & (a[31]^b[31]);
  - acc = 0, cnt = 0, go to RUN.
- DONE with no start: go to IDLE.
- Magnitude of 0x80000000 is 0x80000000, treated as unsigned.
- RUN, one step per cycle:
  - if mplier[0], acc_hi += mcand, with the carry kept in a WIDTH+1-bit sum;
  - then {carry, acc_hi, acc_lo} shifts right 1, and the shifted-out multiplier bit is dropped;
  - cnt++; after the 32nd step (cnt reaches 31), go to FIX.
- FIX:
  - {prod_hi, prod_lo} = neg ? two's-complement negation of acc : acc;
  - go to DONE.
- DONE: done=1 for exactly one cycle.
- Latency:
  - start sampled at edge k; RUN steps occupy edges k+1..k+32; FIX at edge k+33;
  - done is high in the cycle after edge k+33, i.e. 34 cycles after the start cycle.
- busy:
  - high in RUN and FIX;
  - low in IDLE and DONE;
  - never high in the same cycle as done.
- start while busy: ignored, with no effect on the operation in progress.
- start in the DONE cycle: accepted; back-to-back operations are allowed.
- kill:
  - in RUN or FIX, at the next edge go to IDLE, with no done and prod_* unchanged;
  - in IDLE, DONE, or with start, a killed start is not accepted.
- prod_hi and prod_lo change only at the FIX edge. They hold their value until the next completed operation or reset.
- Arithmetic is exact modulo 2^64 for all inputs. Signed result: 64-bit two's-complement product.

Decomposition:
- Shared package mul_pkg holds:
  - WIDTH and CNT_W defaults;
  - state encodings ST_IDLE=0, ST_RUN=1, ST_FIX=2, ST_DONE=3;
  - the latency constant MUL_LAT=34, which hazard logic also uses.
- One natural sub-module, mul_step: the combinational add-and-shift datapath for one iteration (WIDTH+1-bit adder plus shift).
- The controller FSM and registers live in mul32_iter.

Test Plan:
- Unsigned basic: a=0x0000_0007, b=0x0000_0006, is_signed=0 -> done 34 cycles after start; prod_hi=0, prod_lo=0x2A; busy high for exactly 33 cycles.
- Unsigned max: a=b=0xFFFF_FFFF, is_signed=0 -> prod_hi=0xFFFF_FFFE, prod_lo=0x0000_0001.
- Signed mix:
  - a=0xFFFF_FFFD (-3), b=0x0000_0005, is_signed=1 -> prod_hi=0xFFFF_FFFF, prod_lo=0xFFFF_FFF1.
  - a=b=0x8000_0000 signed -> prod_hi=0x4000_0000, prod_lo=0.
- Handshake: start again mid-RUN with different operands -> ignored, first result correct. Start asserted in the DONE cycle -> second result appears 34 cycles later.
- Kill: kill at cycle 10 of RUN -> no done pulse, busy low next cycle, prod_* retain the previous result. A following start completes normally.
- Reset mid-op: reset at cycle 20 of RUN -> next cycle busy=0, done=0, prod_hi=prod_lo=0, state IDLE. No done pulse ever appears for the aborted operation.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared constants for the iterative multiplier: default widths, FSM encoding and
// the start-to-done latency that hazard logic relies on.
package mul_pkg;

  localparam int unsigned DEF_WIDTH = 32;
  localparam int unsigned DEF_CNT_W = 6;

  // Start cycle to done cycle, inclusive of the 32 RUN steps and the FIX step.
  localparam int unsigned MUL_LAT = 34;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } mul_state_e;

endpackage

// File: rtl/mul32_iter_if.sv
// Request/response bundle between the EX-stage issue logic (master) and the multiplier (slave).
interface mul32_iter_if
  import mul_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
);
  logic             start;
  logic             is_signed;
  logic             kill;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] prod_hi;
  logic [WIDTH-1:0] prod_lo;

  modport master (
    output start, is_signed, kill, a, b,
    input  busy, done, prod_hi, prod_lo
  );

  modport slave (
    input  start, is_signed, kill, a, b,
    output busy, done, prod_hi, prod_lo
  );
endinterface

// File: rtl/mul_step.sv
// One radix-2 shift-add iteration: conditional add of the multiplicand into the upper
// accumulator half, then a right shift of {carry, acc_hi, acc_lo} and of the multiplier.
module mul_step
  import mul_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] i_acc_hi,
  input  logic [WIDTH-1:0] i_acc_lo,
  input  logic [WIDTH-1:0] i_mcand,
  input  logic [WIDTH-1:0] i_mplier,
  output logic [WIDTH-1:0] o_acc_hi,
  output logic [WIDTH-1:0] o_acc_lo,
  output logic [WIDTH-1:0] o_mplier
);
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_shifted;

  assign w_sum     = {1'b0, i_acc_hi} + (i_mplier[0] ? {1'b0, i_mcand} : '0);
  // The carry lands in the top bit; the bit shifted off the bottom is discarded.
  assign w_shifted = (2*WIDTH)'({w_sum, i_acc_lo} >> 1);
  assign o_acc_hi  = w_shifted[2*WIDTH-1:WIDTH];
  assign o_acc_lo  = w_shifted[WIDTH-1:0];
  assign o_mplier  = i_mplier >> 1;

endmodule

// File: rtl/mul32_iter.sv
// Iterative signed/unsigned 32x32 multiplier: magnitudes are multiplied over 32 RUN
// cycles, the sign is applied in FIX, and done pulses for one cycle in DONE.
module mul32_iter
  import mul_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input logic         clk,
  input logic         reset,
  mul32_iter_if.slave bus
);
  mul_state_e         r_state;
  mul_state_e         w_state_d;
  logic [WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [WIDTH-1:0]   r_acc_hi;
  logic [WIDTH-1:0]   r_acc_lo;
  logic [WIDTH-1:0]   r_prod_hi;
  logic [WIDTH-1:0]   r_prod_lo;
  logic               r_neg;
  logic [CNT_W-1:0]   r_cnt;

  logic               w_accept;
  logic               w_last;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic [WIDTH-1:0]   w_step_hi;
  logic [WIDTH-1:0]   w_step_lo;
  logic [WIDTH-1:0]   w_step_mplier;
  logic [2*WIDTH-1:0] w_acc;
  logic [2*WIDTH-1:0] w_fixed;

  assign w_accept = bus.start & ~bus.kill & ((r_state == ST_IDLE) | (r_state == ST_DONE));
  assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));

  // The most negative value maps onto itself, which is correct when read as unsigned.
  assign w_mag_a = (bus.is_signed & bus.a[WIDTH-1]) ? (~bus.a + WIDTH'(1)) : bus.a;
  assign w_mag_b = (bus.is_signed & bus.b[WIDTH-1]) ? (~bus.b + WIDTH'(1)) : bus.b;

  assign w_acc   = {r_acc_hi, r_acc_lo};
  assign w_fixed = r_neg ? (~w_acc + (2*WIDTH)'(1)) : w_acc;

  mul_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .i_acc_hi (r_acc_hi),
    .i_acc_lo (r_acc_lo),
    .i_mcand  (r_mcand),
    .i_mplier (r_mplier),
    .o_acc_hi (w_step_hi),
    .o_acc_lo (w_step_lo),
    .o_mplier (w_step_mplier)
  );

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_d = ST_RUN;
      ST_RUN: begin
        if (bus.kill)    w_state_d = ST_IDLE;
        else if (w_last) w_state_d = ST_FIX;
      end
      ST_FIX:  w_state_d = bus.kill ? ST_IDLE : ST_DONE;
      ST_DONE: w_state_d = w_accept ? ST_RUN : ST_IDLE;
      default: w_state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_acc_hi  <= '0;
      r_acc_lo  <= '0;
      r_prod_hi <= '0;
      r_prod_lo <= '0;
      r_neg     <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_state <= w_state_d;
      if (w_accept) begin
        r_mcand  <= w_mag_a;
        r_mplier <= w_mag_b;
        r_neg    <= bus.is_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
        r_acc_hi <= '0;
        r_acc_lo <= '0;
        r_cnt    <= '0;
      end else if ((r_state == ST_RUN) && !bus.kill) begin
        r_acc_hi <= w_step_hi;
        r_acc_lo <= w_step_lo;
        r_mplier <= w_step_mplier;
        r_cnt    <= r_cnt + CNT_W'(1);
      end
      if ((r_state == ST_FIX) && !bus.kill) begin
        r_prod_hi <= w_fixed[2*WIDTH-1:WIDTH];
        r_prod_lo <= w_fixed[WIDTH-1:0];
      end
    end
  end

  assign bus.busy    = (r_state == ST_RUN) | (r_state == ST_FIX);
  assign bus.done    = (r_state == ST_DONE);
  assign bus.prod_hi = r_prod_hi;
  assign bus.prod_lo = r_prod_lo;

endmodule

// File: tb/tb_mul32_iter.sv
// Self-checking bench for mul32_iter: a cycle-level model of the handshake plus exact
// 64-bit arithmetic, compared every cycle, with directed cases pinned to literal results.
module tb_mul32_iter;

  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  mul32_iter_if bus ();

  mul32_iter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] ref_prod(input logic [31:0] x, input logic [31:0] y,
                                           input logic s);
    longint sx, sy;
    if (s) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      return 64'(sx * sy);
    end
    return {32'd0, x} * {32'd0, y};
  endfunction

  // Model: an accepted op stays busy for 33 cycles, then done for one, then result visible.
  bit          m_ok = 1'b0;
  bit          m_act = 1'b0;
  bit          m_done = 1'b0;
  int          m_age = 0;
  logic [63:0] m_exp = '0;
  logic [63:0] m_prod = '0;

  always @(posedge clk) begin
    if (reset) begin
      m_ok   <= 1'b1;
      m_act  <= 1'b0;
      m_done <= 1'b0;
      m_age  <= 0;
      m_prod <= '0;
    end else begin
      m_done <= 1'b0;
      if (m_act) begin
        if (bus.kill) begin
          m_act <= 1'b0;
        end else if (m_age == 32) begin
          m_act  <= 1'b0;
          m_done <= 1'b1;
          m_prod <= m_exp;
        end else begin
          m_age <= m_age + 1;
        end
      end else if (bus.start && !bus.kill) begin
        m_act <= 1'b1;
        m_age <= 0;
        m_exp <= ref_prod(bus.a, bus.b, bus.is_signed);
      end
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      chk("busy", 64'(bus.busy), 64'(m_act));
      chk("done", 64'(bus.done), 64'(m_done));
      chk("prod", {bus.prod_hi, bus.prod_lo}, m_prod);
    end
  end

  // Called at a negedge; optional mid-run start injection, kill or reset (0 = none).
  task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_v, input logic ts,
                        input int inj_at, input int kill_at, input int rst_at,
                        output logic [63:0] res);
    int lat   = 0;
    int nbusy = 0;
    bit got   = 1'b0;
    bus.start     = 1'b1;
    bus.a         = ta;
    bus.b         = tb_v;
    bus.is_signed = ts;
    while (lat < 60 && !got) begin
      @(negedge clk);
      lat++;
      bus.start = 1'b0;
      bus.kill  = 1'b0;
      reset     = 1'b0;
      if (lat == inj_at) begin
        bus.start     = 1'b1;
        bus.a         = $urandom;
        bus.b         = $urandom;
        bus.is_signed = 1'($urandom);
      end
      if (lat == kill_at) bus.kill = 1'b1;
      if (lat == rst_at) reset = 1'b1;
      if (bus.done) got = 1'b1;
      else if (bus.busy) nbusy++;
    end
    if (kill_at > 0 || rst_at > 0) begin
      chk("no_done_after_abort", 64'(got), 64'd0);
    end else begin
      chk("latency", 64'(lat), 64'd34);
      chk("busy_cycles", 64'(nbusy), 64'd33);
    end
    res = {bus.prod_hi, bus.prod_lo};
  endtask

  function automatic logic [31:0] pick();
    case ($urandom % 6)
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  logic [63:0] r;

  initial begin
    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.kill      = 1'b0;
    bus.is_signed = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("reset_prod", {bus.prod_hi, bus.prod_lo}, 64'd0);

    run_op(32'h0000_0007, 32'h0000_0006, 1'b0, 0, 0, 0, r);
    chk("u_7x6", r, 64'h0000_0000_0000_002A);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0, 0, 0, r);
    chk("u_max", r, 64'hFFFF_FFFE_0000_0001);
    run_op(32'hFFFF_FFFD, 32'h0000_0005, 1'b1, 0, 0, 0, r);
    chk("s_m3x5", r, 64'hFFFF_FFFF_FFFF_FFF1);
    run_op(32'h8000_0000, 32'h8000_0000, 1'b1, 0, 0, 0, r);
    chk("s_min_sq", r, 64'h4000_0000_0000_0000);
    run_op(32'd123, 32'd456, 1'b0, 10, 0, 0, r);
    chk("start_ignored", r, 64'd56088);
    run_op(32'h1234, 32'h10, 1'b0, 0, 10, 0, r);
    chk("kill_retains", r, 64'd56088);
    run_op(32'd9, 32'd9, 1'b1, 0, 0, 0, r);
    chk("after_kill", r, 64'd81);
    run_op(32'd5, 32'd5, 1'b0, 0, 0, 20, r);
    chk("reset_clears", r, 64'd0);

    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      bus.start     = ($urandom % 3 == 0);
      bus.kill      = ($urandom % 40 == 0);
      reset         = ($urandom % 400 == 0);
      bus.is_signed = 1'($urandom);
      bus.a         = pick();
      bus.b         = pick();
    end
    @(negedge clk);
    bus.start = 1'b0;
    bus.kill  = 1'b0;
    reset     = 1'b0;
    repeat (40) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
